// File: rtl/fft_r22sdf_reorder_if.sv
// Stream bundle between the FFT output and the reorder buffer.
// slave = reorder block, master = upstream/downstream environment.
interface fft_r22sdf_reorder_if #(
  parameter int N_LOG2 = 10,
  parameter int DW     = 25
);
  logic                     sync_i;
  logic [N_LOG2-1:0]        bin_i;
  logic signed [DW-1:0]     data_re_i;
  logic signed [DW-1:0]     data_im_i;
  logic                     valid_o;
  logic [N_LOG2-1:0]        bin_o;
  logic                     first_o;
  logic                     last_o;
  logic signed [DW-1:0]     data_re_o;
  logic signed [DW-1:0]     data_im_o;

  modport slave (
    input  sync_i, bin_i, data_re_i, data_im_i,
    output valid_o, bin_o, first_o, last_o,
    output data_re_o, data_im_o
  );

  modport master (
    output sync_i, bin_i, data_re_i, data_im_i,
    input  valid_o, bin_o, first_o, last_o,
    input  data_re_o, data_im_o
  );
endinterface

// File: rtl/fft_r22sdf_reorder.sv
// Bit-reversed to natural order converter for fft_r22sdf.
// Ping-pong RAM: one bank filled by bin index, other read 0..N-1.
module fft_r22sdf_reorder #(
  parameter int N      = 1024,
  parameter int N_LOG2 = 10,
  parameter int DW     = 25
) (
  input logic                   clk_i,
  input logic                   rst_i,
  fft_r22sdf_reorder_if.slave   bus
);
  localparam logic [N_LOG2-1:0] LAST = N_LOG2'(N - 1);
  localparam logic [N_LOG2-1:0] ONE  = N_LOG2'(1);

  typedef enum logic {IDLE, READ} state_e;

  state_e            state_q, state_d;
  logic [N_LOG2-1:0] wr_cnt_q, wr_cnt_d;
  logic [N_LOG2-1:0] rd_addr_q, rd_addr_d;
  logic [N_LOG2-1:0] rd_ptr;
  logic              rd_en;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic              rd_start_q, rd_start_d;

  logic [2*DW-1:0]   mem [2*N];

  logic              valid_q;
  logic              first_q;
  logic              last_q;
  logic [N_LOG2-1:0] bin_q;
  logic [DW-1:0]     re_q;
  logic [DW-1:0]     im_q;

  // Frame counting and bank hand-over; a dropped sync aborts the frame
  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    rd_start_d = 1'b0;
    if (bus.sync_i) begin
      if (wr_cnt_q == LAST) begin
        wr_cnt_d   = '0;
        wr_bank_d  = ~wr_bank_q;
        rd_bank_d  = wr_bank_q;
        rd_start_d = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + ONE;
      end
    end else begin
      wr_cnt_d = '0;
    end
  end

  // Read sequencer: start pulse reads bin 0 at once, then walks up
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_ptr    = rd_addr_q;
    rd_en     = 1'b0;
    if (rd_start_q) begin
      rd_en     = 1'b1;
      rd_ptr    = '0;
      rd_addr_d = ONE;
      state_d   = READ;
    end else if (state_q == READ) begin
      rd_en = 1'b1;
      if (rd_addr_q == LAST) begin
        rd_addr_d = '0;
        state_d   = IDLE;
      end else begin
        rd_addr_d = rd_addr_q + ONE;
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wr_cnt_q   <= '0;
      rd_addr_q  <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_addr_q  <= rd_addr_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      rd_start_q <= rd_start_d;
    end
  end

  // Sample RAM write, addressed by natural bin index
  always_ff @(posedge clk_i) begin
    if (!rst_i && bus.sync_i) begin
      mem[{wr_bank_q, bus.bin_i}] <= {bus.data_re_i, bus.data_im_i};
    end
  end

  // Synchronous RAM read with aligned tags; data/bin hold when idle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      bin_q   <= '0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      valid_q <= rd_en;
      first_q <= rd_en && (rd_ptr == '0);
      last_q  <= rd_en && (rd_ptr == LAST);
      if (rd_en) begin
        bin_q        <= rd_ptr;
        {re_q, im_q} <= mem[{rd_bank_q, rd_ptr}];
      end
    end
  end

  assign bus.valid_o   = valid_q;
  assign bus.first_o   = first_q;
  assign bus.last_o    = last_q;
  assign bus.bin_o     = bin_q;
  assign bus.data_re_o = re_q;
  assign bus.data_im_o = im_q;
endmodule

// File: tb/tb_fft_r22sdf_reorder.sv
// Testbench for fft_r22sdf_reorder (N=16, DW=25).
// Frame-level reference model plus a fixed vector table.
module tb_fft_r22sdf_reorder;
  localparam int N  = 16;
  localparam int NL = 4;
  localparam int DW = 25;

  logic clk;
  logic rst;

  fft_r22sdf_reorder_if #(.N_LOG2(NL), .DW(DW)) bus ();

  fft_r22sdf_reorder #(.N(N), .N_LOG2(NL), .DW(DW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            b;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } orec_t;

  typedef struct {
    logic          s;
    logic [NL-1:0] b;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          ev;
    logic [NL-1:0] eb;
    logic          ef;
    logic          el;
    logic [DW-1:0] ere;
    logic [DW-1:0] eim;
  } vec_t;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;

  // reference model state
  int            cnt = 0;
  logic [DW-1:0] fre [N];
  logic [DW-1:0] fim [N];
  orec_t         expq [int];
  int            zero_at = -1;
  logic [NL-1:0] hold_bin = '0;
  logic [DW-1:0] hold_re = '0;
  logic [DW-1:0] hold_im = '0;

  // stimulus buffers
  logic [NL-1:0] pb  [N];
  logic [DW-1:0] pre [N];
  logic [DW-1:0] pim [N];

  vec_t tbl [34];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    else
      n_pass++;
  endtask

  function automatic logic [NL-1:0] brev(int i);
    logic [NL-1:0] v;
    v = NL'(i);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  function automatic logic [56:0] obs();
    return {bus.valid_o, bus.first_o, bus.last_o, bus.bin_o,
            bus.data_re_o, bus.data_im_o};
  endfunction

  // Frame model: a complete frame is re-emitted sorted by bin,
  // bin k two cycles after the last write plus k.
  task automatic model(int t);
    int dk[$];
    if (rst) begin
      cnt = 0;
      foreach (expq[k]) if (k > t) dk.push_back(k);
      foreach (dk[i]) expq.delete(dk[i]);
      zero_at = t + 1;
    end else if (bus.sync_i) begin
      fre[bus.bin_i] = bus.data_re_i;
      fim[bus.bin_i] = bus.data_im_i;
      cnt++;
      if (cnt == N) begin
        for (int k = 0; k < N; k++)
          expq[t + 2 + k] = '{k, fre[k], fim[k]};
        cnt = 0;
      end
    end else begin
      cnt = 0;
    end
  endtask

  task automatic check_cycle(int c);
    orec_t r;
    if (c == zero_at) begin
      chk("reset_out", 64'(obs()), 64'(0));
      hold_bin = '0;
      hold_re  = '0;
      hold_im  = '0;
    end else if (expq.exists(c)) begin
      r = expq[c];
      chk("out", 64'(obs()),
          64'({1'b1, r.b == 0, r.b == N - 1, NL'(r.b), r.re, r.im}));
      hold_bin = NL'(r.b);
      hold_re  = r.re;
      hold_im  = r.im;
      expq.delete(c);
    end else begin
      chk("idle", 64'(obs()),
          64'({3'b000, hold_bin, hold_re, hold_im}));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model(cyc);
    cyc++;
    @(negedge clk);
    check_cycle(cyc);
  endtask

  task automatic drive(logic s, logic [NL-1:0] b,
                       logic [DW-1:0] re, logic [DW-1:0] im);
    bus.sync_i    = s;
    bus.bin_i     = b;
    bus.data_re_i = re;
    bus.data_im_i = im;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, '0, '0, '0);
      step();
    end
  endtask

  task automatic send(int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, pb[i], pre[i], pim[i]);
      step();
    end
    drive(1'b0, '0, '0, '0);
  endtask

  task automatic fill_brev_rand();
    for (int i = 0; i < N; i++) begin
      pb[i]  = brev(i);
      pre[i] = DW'($urandom);
      pim[i] = DW'($urandom);
    end
  endtask

  task automatic fill_perm_rand();
    logic [NL-1:0] tmp;
    int j;
    for (int i = 0; i < N; i++) pb[i] = NL'(i);
    for (int i = N - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = pb[i]; pb[i] = pb[j]; pb[j] = tmp;
    end
    for (int i = 0; i < N; i++) begin
      pre[i] = DW'($urandom);
      pim[i] = DW'($urandom);
    end
  endtask

  initial begin
    // vector table: bit-reversed frame, re=3*bin, im=-bin
    for (int j = 0; j < 34; j++) begin
      tbl[j].s   = (j < N);
      tbl[j].b   = (j < N) ? brev(j) : '0;
      tbl[j].re  = (j < N) ? DW'(3 * int'(brev(j))) : '0;
      tbl[j].im  = (j < N) ? DW'(-int'(brev(j))) : '0;
      tbl[j].ev  = (j >= 16 && j <= 31);
      tbl[j].eb  = NL'(j - 16);
      tbl[j].ef  = (j == 16);
      tbl[j].el  = (j == 31);
      tbl[j].ere = DW'(3 * (j - 16));
      tbl[j].eim = DW'(-(j - 16));
    end

    rst = 1'b1;
    drive(1'b0, '0, '0, '0);
    step();
    step();
    rst = 1'b0;
    idle(3);

    // test 1: table-driven single frame
    for (int j = 0; j < 34; j++) begin
      drive(tbl[j].s, tbl[j].b, tbl[j].re, tbl[j].im);
      step();
      if (tbl[j].ev)
        chk("t1_vec", 64'(obs()),
            64'({1'b1, tbl[j].ef, tbl[j].el, tbl[j].eb,
                 tbl[j].ere, tbl[j].eim}));
      else
        chk("t1_idle", 64'({bus.valid_o, bus.first_o, bus.last_o}),
            64'(0));
    end

    // test 2: four back-to-back frames
    for (int f = 0; f < 4; f++) begin
      fill_brev_rand();
      send(N);
    end
    idle(20);

    // test 3: partial frame of 7 then a full frame
    fill_brev_rand();
    send(7);
    idle(1);
    fill_brev_rand();
    send(N);
    idle(20);

    // test 4: reset in the middle of an output frame
    fill_brev_rand();
    send(N);
    idle(8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(4);
    fill_brev_rand();
    send(N);
    idle(20);

    // test 5: two frames with a 5-cycle gap
    fill_brev_rand();
    send(N);
    idle(5);
    fill_brev_rand();
    send(N);
    idle(20);

    // test 6: signed extremes pass bit-exact
    for (int i = 0; i < N; i++) begin
      pb[i]  = brev(i);
      pre[i] = i[0] ? 25'h1FFFFFF : 25'h0FFFFFF;
      pim[i] = i[0] ? 25'h1000000 : 25'h0000001;
    end
    send(N);
    idle(20);

    // reset in the middle of a write frame
    fill_brev_rand();
    send(9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    fill_brev_rand();
    send(N);
    idle(20);

    // randomized: shuffled bin order, random gaps and aborts
    for (int f = 0; f < 12; f++) begin
      if ($urandom_range(3, 0) == 0) begin
        fill_perm_rand();
        send($urandom_range(N - 1, 1));
        idle(1);
      end
      fill_perm_rand();
      send(N);
      idle($urandom_range(3, 0));
    end
    idle(25);

    chk("drain", 64'(expq.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
